// File: rtl/mux_stage_pkg.sv
// Shared types and constants for the mux operand stager.
package mux_stage_pkg;

  typedef logic [1:0] sel_code_t;

  // One queued operand bundle as it sits in the FIFO.
  typedef struct packed {
    logic      sweep;
    sel_code_t sel;
    logic      a;
    logic      b;
    logic      c;
    logic      d;
  } stage_entry_t;

  localparam int SWEEP_BEATS = 4;

  // Select code carried by the final beat of a sweep.
  localparam sel_code_t LAST_SWEEP_SEL = sel_code_t'(SWEEP_BEATS - 1);

  typedef enum logic {
    IDLE,
    ISSUE
  } stage_state_t;

endpackage

// File: rtl/mux_stage_fifo.sv
// Small synchronous FIFO of stage entries; pointers carry an extra wrap bit
// so that full and empty can be told apart when the indices match.
module mux_stage_fifo
  import mux_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  stage_entry_t wdata,
  input  logic         pop,
  output stage_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  stage_entry_t mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; a push into a full FIFO or a pop from an empty one is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage write.
  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, so clearing the array would add logic for nothing.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mux_operand_stager.sv
// Buffers operand bundles and issues them as registered, glitch-free
// select/operand beats to the downstream 4-input mux tree.
module mux_operand_stager
  import mux_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sweep,
  input  logic [1:0]       in_sel,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  input  logic             in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s1,
  output logic             out_s2,
  output logic             out_a,
  output logic             out_b,
  output logic             out_c,
  output logic             out_d,
  output logic             out_last,
  output logic [CNT_W-1:0] beat_count
);

  stage_entry_t wdata;
  stage_entry_t head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;

  stage_state_t state_q, state_d;
  stage_entry_t cur_q, cur_d;
  sel_code_t    beat_idx_q, beat_idx_d;
  logic         last_q, last_d;
  logic         fire;
  logic         beat_done;

  // Acceptance depends only on occupancy (and reset), never on out_ready.
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign wdata    = {in_sweep, in_sel, in_a, in_b, in_c, in_d};

  mux_stage_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign fire      = (state_q == ISSUE) && out_ready;
  assign beat_done = !cur_q.sweep || (beat_idx_q == LAST_SWEEP_SEL);

  // Next-state logic: advance through a sweep, or load the next bundle
  // (in the same edge as the final handshake, so back-to-back bundles have no bubble).
  // NOTE: every variable gets a default first so no path can infer a latch;
  // combinational blocks use blocking assignments throughout.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    beat_idx_d = beat_idx_q;
    last_d     = last_q;
    pop        = 1'b0;

    if (fire && !beat_done) begin
      beat_idx_d = beat_idx_q + 2'd1;
      cur_d.sel  = beat_idx_q + 2'd1;
      last_d     = ((beat_idx_q + 2'd1) == LAST_SWEEP_SEL);
    end else if ((state_q == IDLE) || fire) begin
      if (!empty) begin
        pop        = 1'b1;
        cur_d      = head;
        if (head.sweep) cur_d.sel = '0;
        beat_idx_d = '0;
        last_d     = !head.sweep;
        state_d    = ISSUE;
      end else begin
        last_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      beat_idx_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      beat_idx_q <= beat_idx_d;
      last_q     <= last_d;
    end
  end

  // Saturating count of completed output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= '0;
    end else if (fire && (beat_count != '1)) begin
      beat_count <= beat_count + CNT_W'(1);
    end
  end

  assign out_valid = (state_q == ISSUE);
  assign out_last  = last_q;
  assign out_s1    = cur_q.sel[0];
  assign out_s2    = cur_q.sel[1];
  assign out_a     = cur_q.a;
  assign out_b     = cur_q.b;
  assign out_c     = cur_q.c;
  assign out_d     = cur_q.d;

endmodule

// File: tb/tb_mux_operand_stager.sv
// Self-checking bench: a beat-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mux_operand_stager;

  localparam int DEPTH   = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sweep = 1'b0;
  logic [1:0]       in_sel = 2'b00;
  logic             in_a = 1'b0, in_b = 1'b0, in_c = 1'b0, in_d = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_s1, out_s2;
  logic             out_a, out_b, out_c, out_d;
  logic             out_last;
  logic [CNT_W-1:0] beat_count;

  always #5 clk = ~clk;

  mux_operand_stager #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sweep   (in_sweep),
    .in_sel     (in_sel),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c       (in_c),
    .in_d       (in_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s1     (out_s1),
    .out_s2     (out_s2),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_last   (out_last),
    .beat_count (beat_count)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] data;
    logic       last;
  } beat_t;

  beat_t expq[$];
  int    mcount = 0;
  int    n_cmp  = 0;
  int    n_bad  = 0;
  bit    seen_reset = 1'b0;
  beat_t exp_beat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // A bundle expands to the list of beats the mux must see.
  task automatic expand(input logic sweep, input logic [1:0] sel, input logic [3:0] data);
    beat_t bt;
    if (sweep) begin
      for (int k = 0; k < 4; k++) begin
        bt.sel  = 2'(k);
        bt.data = data;
        bt.last = (k == 3);
        expq.push_back(bt);
      end
    end else begin
      bt.sel  = sel;
      bt.data = data;
      bt.last = 1'b1;
      expq.push_back(bt);
    end
  endtask

  // Compare process: check current outputs against the model, then apply the
  // handshakes that will occur on the coming rising edge.
  always @(negedge clk) begin
    if (seen_reset) begin
      check("beat_count", 32'(beat_count), 32'(mcount));
      if (rst) check("in_ready_in_reset", 32'(in_ready), 32'd0);
      if (out_valid === 1'b1) begin
        if (expq.size() == 0) begin
          check("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          exp_beat = expq[0];
          check("beat_sel",  32'({out_s2, out_s1}), 32'(exp_beat.sel));
          check("beat_data", 32'({out_a, out_b, out_c, out_d}), 32'(exp_beat.data));
          check("beat_last", 32'(out_last), 32'(exp_beat.last));
        end
      end
      if (rst) begin
        expq.delete();
        mcount = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (expq.size() > 0) void'(expq.pop_front());
          if (mcount < CNT_MAX) mcount++;
        end
        if (in_valid && in_ready) expand(in_sweep, in_sel, {in_a, in_b, in_c, in_d});
      end
    end
    if (rst) seen_reset = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic sweep, input logic [1:0] sel, input logic [3:0] data);
    in_valid = 1'b1;
    in_sweep = sweep;
    in_sel   = sel;
    {in_a, in_b, in_c, in_d} = data;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last), 32'd0);
    check("rst_outputs",   32'({out_s2, out_s1, out_a, out_b, out_c, out_d}), 32'd0);
    check("rst_beat_count", 32'(beat_count), 32'd0);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready_release", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int hs;
    bit done;

    // Single beat: sel=2, data 1011, two-cycle latency.
    do_reset();
    out_ready = 1'b1;
    set_bundle(1'b0, 2'd2, 4'b1011);
    tick();
    in_valid = 1'b0;
    check("single_lat_early", 32'(out_valid), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_s2", 32'(out_s2), 32'd1);
    check("single_s1", 32'(out_s1), 32'd0);
    check("single_data", 32'({out_a, out_b, out_c, out_d}), 32'hB);
    check("single_last", 32'(out_last), 32'd1);
    tick();
    check("single_count", 32'(beat_count), 32'd1);
    check("single_done", 32'(out_valid), 32'd0);

    // Sweep: four consecutive beats, sel 0..3, last only on the fourth.
    do_reset();
    out_ready = 1'b1;
    set_bundle(1'b1, 2'd3, 4'b0110);
    tick();
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("sweep_valid", 32'(out_valid), 32'd1);
      check("sweep_sel", 32'({out_s2, out_s1}), 32'(k));
      check("sweep_data", 32'({out_a, out_b, out_c, out_d}), 32'h6);
      check("sweep_last", 32'(out_last), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("sweep_count", 32'(beat_count), 32'd4);
    check("sweep_done", 32'(out_valid), 32'd0);

    // Back-pressure: DEPTH+1 bundles accepted, then in_ready holds low.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      check("bp_accept", 32'(in_ready), 32'd1);
      set_bundle(1'b0, 2'(i + 1), 4'(4 * i + 3));
      tick();
    end
    set_bundle(1'b0, 2'd0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      check("bp_full", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      check("bp_drain_nobubble", 32'(out_valid), 32'd1);
      tick();
    end
    check("bp_drain_end", 32'(out_valid), 32'd0);
    check("bp_drain_count", 32'(beat_count), 32'(DEPTH + 1));

    // Random stall during a sweep.
    do_reset();
    set_bundle(1'b1, 2'd1, 4'b1001);
    tick();
    in_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      done = (beat_count == 4);
    end
    check("stall_sweep_count", 32'(beat_count), 32'd4);

    // Randomized mixed traffic, then drain.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sweep  = ($urandom_range(0, 3) == 0);
      in_sel    = 2'($urandom_range(0, 3));
      {in_a, in_b, in_c, in_d} = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && (expq.size() != 0 || out_valid); i++) tick();
    check("random_drain_queue", 32'(expq.size()), 32'd0);
    check("random_drain_valid", 32'(out_valid), 32'd0);

    // Reset mid-sweep with two bundles queued.
    do_reset();
    set_bundle(1'b1, 2'd0, 4'b1100);
    tick();
    set_bundle(1'b0, 2'd1, 4'b0011);
    tick();
    set_bundle(1'b0, 2'd2, 4'b0101);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("mid_sweep_sel", 32'({out_s2, out_s1}), 32'd2);
    check("mid_sweep_count", 32'(beat_count), 32'd2);
    rst = 1'b1;
    tick();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_count", 32'(beat_count), 32'd0);
    check("abort_in_ready_low", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_stale", 32'(out_valid), 32'd0);
    end

    // Saturation: 300 handshakes with an 8-bit counter.
    do_reset();
    out_ready = 1'b1;
    set_bundle(1'b1, 2'd0, 4'b1010);
    hs = 0;
    for (int i = 0; i < 1000 && hs < 300; i++) begin
      if (out_valid && out_ready) hs++;
      tick();
    end
    in_valid = 1'b0;
    check("sat_handshakes", 32'(hs), 32'd300);
    check("sat_count", 32'(beat_count), 32'd255);
    tick();
    check("sat_hold", 32'(beat_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_operand_stager.md
# mux_operand_stager

Upstream feeder for the 4-input select-mux tree. Accepts operand bundles `{a,b,c,d}` plus a 2-bit select code over a valid/ready handshake and buffers them in a small FIFO. It drives registered, glitch-free `s1/s2/a/b/c/d` into the mux for exactly one accepted beat each. An optional sweep mode replays one bundle across all four select codes, so the downstream mux can be exercised exhaustively without re-sending data.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the issued-beat counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream bundle valid.
- `in_ready` out 1: stager can accept; equals `!full`.
- `in_sweep` in 1: 1 = issue 4 beats (sel 0..3); 0 = single beat using `in_sel`.
- `in_sel` in 2: select code for single mode; ignored in sweep.
- `in_a`, `in_b`, `in_c`, `in_d` in 1 each: operand bits.
- `out_valid` out 1: mux-side beat valid.
- `out_ready` in 1: downstream consumed beat.
- `out_s1`, `out_s2` out 1 each: `s1 = sel[0]`, `s2 = sel[1]`.
- `out_a`, `out_b`, `out_c`, `out_d` out 1 each: registered operands.
- `out_last` out 1: final beat of current bundle.
- `beat_count` out `CNT_W`: accepted output beats, saturating.

## Operation
- FIFO stores entries `{sweep, sel, a, b, c, d}`.
- Push when `in_valid && in_ready`.
- `in_ready` depends only on FIFO occupancy. There is no combinational path from `out_ready`. When full, no push occurs even if a pop happens in the same cycle.
- FSM states: `IDLE`, `ISSUE`.
  - `IDLE`: `out_valid=0`. If FIFO is non-empty, load the head into the output register, pop it, set `beat_idx=0`, go to `ISSUE`. Loaded sel is `in_sel` for single mode, `2'b00` for sweep.
  - `ISSUE`: `out_valid=1`. All `out_*` are held stable while `!out_ready`.
  - On handshake in a sweep entry with `beat_idx<3`: increment `beat_idx`, set sel to `beat_idx+1`, keep data unchanged, stay in `ISSUE`.
  - On handshake on the last beat: if FIFO is non-empty, load and pop the next head in the same edge (no bubble) and stay in `ISSUE`. Otherwise go to `IDLE`.
- `out_last` is 1 when the current beat is single mode, or sweep with `beat_idx==3`.
- `beat_count` increments on each `out_valid && out_ready` and holds at all-ones.
- FIFO pointers wrap modulo `DEPTH`, with an extra wrap bit for full/empty discrimination.

## Timing
- Reset values:
  - `out_valid=0`, `out_last=0`.
  - `out_s1/out_s2/out_a..out_d=0`.
  - `beat_count=0`, FSM `IDLE`, FIFO empty.
  - `in_ready=0` while `rst` is high; 1 in the first cycle after release.
- Latency: push at edge t into an empty stager with FSM idle → `out_valid=1` after edge t+1. Fixed 2-cycle latency, no bypass.
- Throughput: 1 beat/cycle with `out_ready` held high and FIFO non-empty.
- Sweep bundle: exactly 4 consecutive handshakes, sel 0,1,2,3.
- Simultaneous push and pop when not full: both happen; occupancy unchanged.
- Reset mid-operation: pending FIFO entries and any partially issued sweep are dropped. `out_valid` is 0 after the reset edge. No beat is counted for an aborted sweep.
- All outputs are registered. No combinational input-to-output paths.

## Structure
- `mux_stage_pkg`:
  - `sel_code_t` (2-bit).
  - `stage_entry_t` packed struct `{sweep, sel, a, b, c, d}`.
  - `SWEEP_BEATS=4`.
  - FSM state enum `{IDLE, ISSUE}`.
- One sub-module: `mux_stage_fifo`, a parameterised synchronous FIFO of `stage_entry_t` with `full`/`empty`, push/pop.
- Top holds the FSM, `beat_idx`, output registers and the counter.

## Test plan
- Reset then single push `{sel=2, a..d=1,0,1,1}` with `out_ready=1`:
  - `out_valid` rises 2 cycles after push.
  - `s2=1`, `s1=0`, `out_last=1`, `beat_count=1`.
- Sweep push with `out_ready=1`:
  - Four consecutive beats, `{s2,s1}` = 00, 01, 10, 11.
  - Data constant; `out_last` only on the 4th beat; `beat_count=4`.
- `out_ready=0`, push `DEPTH+1` bundles:
  - `in_ready` drops after `DEPTH` pushes plus the one loaded into the output register.
  - Outputs stay stable, no extra entry is accepted.
  - Release `out_ready`: bundles drain in order with no bubbles.
- Random `out_ready` stall during a sweep:
  - Each beat is held until its handshake; sel never skips or repeats.
- Assert `rst` mid-sweep (after beat 1) with 2 entries queued:
  - Next cycle `out_valid=0`, `beat_count=0`, `in_ready=1` after release.
  - No stale beat appears afterwards.
- Drive 300 handshakes with `CNT_W=8`:
  - `beat_count` saturates at 255.
